// File: rtl/ser_pkg.sv
// ============================================================================
// Module   : ser_pkg
// Brief    : Shared types and defaults for the serializer_piso block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ser_pkg;

  localparam int SER_WIDTH_DEFAULT = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

endpackage : ser_pkg

`default_nettype wire

// File: rtl/ser_bit_cell.sv
// ============================================================================
// Module   : ser_bit_cell
// Brief    : One shift-register slice: 2:1 load/shift mux feeding an async-reset flop.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ser_bit_cell (
  input  logic clk,
  input  logic rst,
  input  logic sel_i,
  input  logic load_bit_i,
  input  logic shift_bit_i,
  output logic q_o
);

  logic bit_d;
  logic bit_q;

  assign bit_d = sel_i ? load_bit_i : shift_bit_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_q <= 1'b0;
    end else begin
      bit_q <= bit_d;
    end
  end

  assign q_o = bit_q;

endmodule : ser_bit_cell

`default_nettype wire

// File: rtl/serializer_piso.sv
// ============================================================================
// Module   : serializer_piso
// Brief    : Parallel-in serial-out serializer, LSB first, with frame framing.
//            Define SERIALIZER_PARITY_EN to append an even-parity bit per frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serializer_piso
  import ser_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             last
);

  localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef SERIALIZER_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  ser_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shift_in;
  logic             load_sel;
  logic             frame_bit;
  logic             at_last;

  // Loads are only honoured in IDLE; a request during a frame is dropped.
  assign load_sel = (state_q == IDLE) && load_valid;
  assign shift_in = {1'b0, shreg_q[WIDTH-1:1]};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    ser_bit_cell u_cell (
      .clk         (clk),
      .rst         (rst),
      .sel_i       (load_sel),
      .load_bit_i  (din[i]),
      .shift_bit_i (shift_in[i]),
      .q_o         (shreg_q[i])
    );
  end

  assign at_last = (cnt_q == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_valid) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
          end
        end
        SHIFT: begin
          if (at_last) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

`ifdef SERIALIZER_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (load_sel) begin
      parity_q <= ^din;
    end
  end

  // Past the data bits the slot carries the captured parity.
  assign frame_bit = (cnt_q == CNT_W'(WIDTH)) ? parity_q : shreg_q[0];
`else
  assign frame_bit = shreg_q[0];
`endif

  // Every output decodes registered state only, so rst forces them at once.
  assign ready      = (state_q == IDLE);
  assign sout_valid = (state_q == SHIFT);
  assign sout       = sout_valid & frame_bit;
  assign last       = sout_valid & at_last;

endmodule : serializer_piso

`default_nettype wire

// File: tb/tb_serializer_piso.sv
// ============================================================================
// Module   : tb_serializer_piso
// Brief    : Directed self-checking bench for serializer_piso at WIDTH=8.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serializer_piso;

`ifdef SERIALIZER_PARITY_EN
  localparam int FLEN = 9;
`else
  localparam int FLEN = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       load_valid = 1'b0;
  logic       ready;
  logic       sout;
  logic       sout_valid;
  logic       last;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  serializer_piso #(.WIDTH(8)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .load_valid (load_valid),
    .ready      (ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .last       (last)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic got, input logic exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%b expected=%b", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Loads word, then checks every frame cycle plus the IDLE cycle that follows.
  // poke>0 pulses load_valid with din=0xFF during that frame cycle.
  task automatic run_frame(input logic [7:0] word, input logic exp_par, input int poke);
    din        = word;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    din        = 8'h00;
    for (int c = 1; c <= FLEN; c++) begin
      cyc = c;
      check_eq("valid", sout_valid, 1'b1);
      check_eq("sout",  sout, (c <= 8) ? word[c-1] : exp_par);
      check_eq("last",  last, (c == FLEN));
      check_eq("ready", ready, 1'b0);
      if (c == poke) begin
        din        = 8'hFF;
        load_valid = 1'b1;
      end
      tick();
      load_valid = 1'b0;
      din        = 8'h00;
    end
    cyc = FLEN + 1;
    check_eq("gap_ready", ready, 1'b1);
    check_eq("gap_valid", sout_valid, 1'b0);
    check_eq("gap_sout",  sout, 1'b0);
    check_eq("gap_last",  last, 1'b0);
  endtask

  initial begin
    // Reset state, with a load request held during reset that must not be taken.
    din        = 8'hA5;
    load_valid = 1'b1;
    #2;
    check_eq("rst_ready", ready, 1'b1);
    check_eq("rst_valid", sout_valid, 1'b0);
    check_eq("rst_sout",  sout, 1'b0);
    check_eq("rst_last",  last, 1'b0);
    tick();
    tick();
    check_eq("rst_hold_ready", ready, 1'b1);
    check_eq("rst_hold_valid", sout_valid, 1'b0);
    load_valid = 1'b0;
    rst        = 1'b0;
    tick();
    check_eq("post_rst_valid", sout_valid, 1'b0);

    // Basic frame 0xA5 -> 1,0,1,0,0,1,0,1 ; even parity 0.
    run_frame(8'hA5, 1'b0, 0);

    // Boundary words, back to back with the single IDLE gap.
    run_frame(8'h00, 1'b0, 0);
    run_frame(8'hFF, 1'b0, 0);

    // Parity pattern 0x07 -> 1,1,1,0,0,0,0,0 ; parity 1.
    run_frame(8'h07, 1'b1, 0);

    // Busy load at cycle 3 of a 0x00 frame must be ignored.
    run_frame(8'h00, 1'b0, 3);
    tick();
    check_eq("busy_no_restart", sout_valid, 1'b0);

    // Reset mid-frame at cycle 4 of 0x3C.
    din        = 8'h3C;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int c = 1; c < 4; c++) begin
      cyc = c;
      tick();
    end
    cyc = 4;
    check_eq("mid_valid_pre", sout_valid, 1'b1);
    check_eq("mid_sout_pre",  sout, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("abort_valid", sout_valid, 1'b0);
    check_eq("abort_sout",  sout, 1'b0);
    check_eq("abort_last",  last, 1'b0);
    check_eq("abort_ready", ready, 1'b1);
    tick();
    #2;
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cyc = 100 + c;
      tick();
      check_eq("quiet_valid", sout_valid, 1'b0);
      check_eq("quiet_sout",  sout, 1'b0);
      check_eq("quiet_ready", ready, 1'b1);
    end

    // Fresh frame after the abort: 0x5A -> 0,1,0,1,1,0,1,0 ; parity 0.
    run_frame(8'h5A, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_serializer_piso

`default_nettype wire

// File: doc/serializer_piso.md
SERIALIZER_PISO -- requirements
Module: serializer_piso

Interface
REQ-001 Parameter: WIDTH, default 8, number of data bits per frame (legal range 2..32).
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: din  input  WIDTH  parallel word to serialize.
REQ-005 Port: load_valid  input  1  request to accept din this cycle.
REQ-006 Port: ready  output  1  high when a new word can be accepted.
REQ-007 Port: sout  output  1  serial data bit, LSB first.
REQ-008 Port: sout_valid  output  1  sout carries a frame bit this cycle.
REQ-009 Port: last  output  1  high with the final bit of a frame.

Function
REQ-010 The block SHALL implement two states: IDLE and SHIFT.
REQ-011 ready SHALL equal 1 exactly when the state is IDLE (combinational from state).
REQ-012 Accept: at a rising edge with state IDLE and load_valid=1, the block SHALL capture din into the shift register, clear the bit counter and enter SHIFT.
REQ-013 load_valid while in SHIFT SHALL be ignored; din is not sampled.
REQ-014 Latency: din[0] SHALL appear on sout with sout_valid=1 in the first cycle after the accepting edge.
REQ-015 In SHIFT, each edge SHALL shift right by one, fill the MSB with 0 and increment the counter; sout SHALL equal the register LSB.
REQ-016 A frame SHALL be WIDTH bits (WIDTH+1 with REQ-024). last=1 only with the final bit. On the following edge the block SHALL return to IDLE.
REQ-017 Minimum frame gap SHALL be one IDLE cycle. Back-to-back frames without an IDLE cycle are not supported.
REQ-018 When sout_valid=0, sout and last SHALL be 0.
REQ-019 Counter width SHALL be $clog2(WIDTH+1) bits. Terminal count SHALL be compared exactly, with no wrap-around beyond the frame length.
REQ-020 Per bit, load-versus-shift selection SHALL be a 2:1 mux (sel=1 selects din) feeding a flop.

Reset
REQ-021 Asserting rst SHALL immediately force IDLE, clear the shift register and counter, and drive ready=1, sout_valid=0, sout=0 and last=0.
REQ-022 rst asserted mid-frame SHALL abort the frame. No further bits of that frame SHALL be emitted.
REQ-023 The first accept after reset SHALL occur no earlier than the first rising edge with rst=0.

Configuration
REQ-024 With macro SERIALIZER_PARITY_EN defined, the block SHALL append one even-parity bit (XOR of the captured din) after the data bits. sout_valid SHALL be 1 for that bit and last SHALL move to the parity bit.
REQ-025 Without SERIALIZER_PARITY_EN, the frame SHALL be WIDTH data bits only and no parity logic SHALL be synthesized.

Structure
REQ-026 Shared package ser_pkg SHALL hold the state typedef (IDLE, SHIFT) and the default WIDTH constant.
REQ-027 One sub-module, ser_bit_cell, SHALL contain the per-bit 2:1 load/shift mux plus an async-reset flop. It SHALL be instantiated WIDTH times.
REQ-028 Gate and propagation delays SHALL use the team's existing timing macros and no new delay constants.

Verification (WIDTH=8)
REQ-029 Basic frame: load din=0xA5 with load_valid=1 in IDLE -> sout = 1,0,1,0,0,1,0,1 in cycles 1..8; sout_valid=1 in cycles 1..8; last=1 in cycle 8 only; ready=1 again in cycle 9.
REQ-030 Busy load: pulse load_valid with din=0xFF at cycle 3 of a 0x00 frame -> all eight bits are 0; 0xFF is never emitted.
REQ-031 Reset mid-frame: assert rst at cycle 4 of a 0x3C frame -> sout_valid, sout and last are 0 and ready=1 immediately; no bits are emitted after rst deasserts until a new load.
REQ-032 Parity (SERIALIZER_PARITY_EN): din=0x07 -> bits 1,1,1,0,0,0,0,0 then parity bit 1 in cycle 9 with last=1. din=0xA5 -> parity bit 0.
REQ-033 Boundary words: din=0x00 and din=0xFF each give exactly 8 valid bits, last in cycle 8, and one IDLE cycle before a second load is accepted.
